// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip RAM with 1-cycle read latency.
// Optional power-up RAM clear is enabled by defining ONCHIP_MEM_CLEAR_EN.
`timescale 1ns/1ps

// Handshake: a master's request (read or write held high) is accepted in every cycle where its
// waitrequest is low; a read accepted in cycle N returns readdatavalid/readdata in cycle N+1.
module onchip_mem_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 10000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                busy,
  output logic                dbg_state
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;
  state_t state, state_nxt;

`ifdef ONCHIP_MEM_CLEAR_EN
  localparam state_t ST_INIT = ST_CLEAR;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  logic [ADDR_W-1:0] clr_cnt;
`else
  localparam state_t ST_INIT = ST_RUN;
`endif

  logic              req0, req1, run, g0, g1, granted, last_grant;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_write, sel_oor, rd_acc;
  logic              rd_pend, rd_owner, rd_oor;
  logic [DATA_W-1:0] rd_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
`ifdef ONCHIP_MEM_CLEAR_EN
    if (state == ST_CLEAR && clr_cnt == LAST_ADDR) state_nxt = ST_RUN;
`endif
  end

`ifdef ONCHIP_MEM_CLEAR_EN
  // Walks every implemented word once; the FSM leaves CLEAR before the counter could wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  clr_cnt <= '0;
    else if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
  end
  assign busy = ~reset & (state == ST_CLEAR);
`else
  assign busy = 1'b0;
`endif

  assign dbg_state = (state == ST_RUN);

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  assign run  = ~reset & (state == ST_RUN);
  // On conflict the master that was not granted last time wins.
  assign g0      = run & req0 & (~req1 | last_grant);
  assign g1      = run & req1 & (~req0 | ~last_grant);
  assign granted = g0 | g1;

  assign sel_addr  = g1 ? m1_address : m0_address;
  assign sel_write = g1 ? m1_write   : m0_write;
  assign sel_oor   = ({1'b0, sel_addr} >= DEPTH_X);
  assign rd_acc    = granted & ~sel_write;

  assign m0_waitrequest = ~g0;
  assign m1_waitrequest = ~g1;

  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    if (granted) begin
      mem_address    = sel_addr;
      mem_byteenable = g1 ? m1_byteenable : m0_byteenable;
      mem_writedata  = g1 ? m1_writedata  : m0_writedata;
      mem_chipselect = ~sel_oor;
      mem_write      = sel_write;
    end
`ifdef ONCHIP_MEM_CLEAR_EN
    else if (~reset && state == ST_CLEAR) begin
      mem_address    = clr_cnt;
      mem_byteenable = '1;
      mem_chipselect = 1'b1;
      mem_write      = 1'b1;
    end
`endif
  end

  assign mem_clken = 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      rd_pend    <= 1'b0;
      rd_owner   <= 1'b0;
      rd_oor     <= 1'b0;
    end else begin
      if (granted) last_grant <= g1;
      rd_pend  <= rd_acc;
      rd_owner <= g1;
      rd_oor   <= sel_oor;
    end
  end

  // Out-of-range reads return zero regardless of what the RAM drives.
  assign rd_data          = rd_oor ? '0 : mem_readdata;
  assign m0_readdatavalid = rd_pend & ~rd_owner;
  assign m1_readdatavalid = rd_pend & rd_owner;
  assign m0_readdata      = m0_readdatavalid ? rd_data : '0;
  assign m1_readdata      = m1_readdatavalid ? rd_data : '0;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed self-checking bench for onchip_mem_arbiter with a behavioural 1-cycle-latency RAM.
`timescale 1ns/1ps

module tb_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] m0_address = '0, m1_address = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [13:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken, busy, dbg_state;
  logic [31:0] mem_writedata, mem_readdata;

  int checks = 0;
  int fails  = 0;

  logic [31:0] ram [0:16383];
  logic [31:0] ram_q = '0;

  onchip_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  // RAM model: byte-lane writes, registered reads
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        ram_q <= ram[mem_address];
      end
    end
  end
  assign mem_readdata = ram_q;

  // driver tasks
  task automatic idle();
    m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
  endtask

  task automatic drive_m0(input logic rd, input logic wr, input logic [13:0] a,
                          input logic [3:0] be, input logic [31:0] d);
    m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
  endtask

  task automatic drive_m1(input logic rd, input logic wr, input logic [13:0] a,
                          input logic [3:0] be, input logic [31:0] d);
    m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
  endtask

  task automatic wait_ready();
    #1;
`ifdef ONCHIP_MEM_CLEAR_EN
    begin
      int n = 0;
      while (busy === 1'b1 && n < 10100) begin
        @(negedge clk); #1; n++;
      end
      checks++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL wait_ready busy=%b after %0d cycles, required 0", busy, n);
      end
    end
`endif
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_ready();
  endtask

  task automatic test_reset();
    drive_m0(1, 0, 14'h5, 4'hF, 32'h0);
    drive_m1(0, 1, 14'h6, 4'hF, 32'h1);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (m0_waitrequest !== 1'b1) begin fails++; $display("FAIL rst_m0_wait got %b want 1", m0_waitrequest); end
    checks++; if (m1_waitrequest !== 1'b1) begin fails++; $display("FAIL rst_m1_wait got %b want 1", m1_waitrequest); end
    checks++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b%b want 00", m0_readdatavalid, m1_readdatavalid); end
    checks++; if (m0_readdata !== 32'h0 || m1_readdata !== 32'h0) begin fails++; $display("FAIL rst_rdata got %h/%h want 0", m0_readdata, m1_readdata); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (mem_chipselect !== 1'b0 || mem_write !== 1'b0 || mem_address !== 14'h0 || mem_byteenable !== 4'h0 || mem_writedata !== 32'h0) begin
      fails++; $display("FAIL rst_mem cs=%b wr=%b a=%h be=%h wd=%h want all 0", mem_chipselect, mem_write, mem_address, mem_byteenable, mem_writedata);
    end
    checks++; if (mem_clken !== 1'b1) begin fails++; $display("FAIL rst_clken got %b want 1", mem_clken); end
    @(negedge clk);
    drive_m1(0, 0, 14'h0, 4'h0, 32'h0);
    reset = 1'b0;
`ifdef ONCHIP_MEM_CLEAR_EN
    #1;
    checks++; if (busy !== 1'b1 || m0_waitrequest !== 1'b1) begin fails++; $display("FAIL clr_start busy=%b wait=%b want 1/1", busy, m0_waitrequest); end
`endif
    wait_ready();
    checks++; if (m0_waitrequest !== 1'b0) begin fails++; $display("FAIL first_grant got %b want 0", m0_waitrequest); end
  endtask

  task automatic test_round_robin();
    logic exp_q[$];
    logic exp_g, prev;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drive_m0(1, 0, 14'h20 + 14'(k), 4'hF, 32'h0);
      drive_m1(1, 0, 14'h30 + 14'(k), 4'hF, 32'h0);
      #1;
      exp_g = 1'(k % 2);
      checks++; if (m0_waitrequest !== exp_g) begin fails++; $display("FAIL rr_m0_wait k=%0d got %b want %b", k, m0_waitrequest, exp_g); end
      checks++; if (m1_waitrequest !== ~exp_g) begin fails++; $display("FAIL rr_m1_wait k=%0d got %b want %b", k, m1_waitrequest, ~exp_g); end
      checks++; if (mem_address !== (exp_g ? 14'h30 + 14'(k) : 14'h20 + 14'(k))) begin fails++; $display("FAIL rr_addr k=%0d got %h", k, mem_address); end
      if (exp_q.size() > 0) begin
        prev = exp_q.pop_front();
        checks++; if (m0_readdatavalid !== ~prev || m1_readdatavalid !== prev) begin fails++; $display("FAIL rr_valid k=%0d got %b%b owner %b", k, m0_readdatavalid, m1_readdatavalid, prev); end
      end else begin
        checks++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin fails++; $display("FAIL rr_valid0 got %b%b want 00", m0_readdatavalid, m1_readdatavalid); end
      end
      exp_q.push_back(exp_g);
    end
    @(negedge clk);
    idle();
    #1;
    prev = exp_q.pop_front();
    checks++; if (m0_readdatavalid !== ~prev || m1_readdatavalid !== prev) begin fails++; $display("FAIL rr_valid_last got %b%b owner %b", m0_readdatavalid, m1_readdatavalid, prev); end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    drive_m0(0, 1, 14'h5, 4'hF, 32'hDEADBEEF);
    #1;
    checks++; if (m0_waitrequest !== 1'b0) begin fails++; $display("FAIL wr_wait got %b want 0", m0_waitrequest); end
    checks++; if (mem_chipselect !== 1'b1 || mem_write !== 1'b1 || mem_address !== 14'h5 || mem_writedata !== 32'hDEADBEEF) begin
      fails++; $display("FAIL wr_mem cs=%b wr=%b a=%h wd=%h want 1 1 0005 deadbeef", mem_chipselect, mem_write, mem_address, mem_writedata);
    end
    @(negedge clk);
    drive_m0(1, 0, 14'h5, 4'hF, 32'h0);
    #1;
    checks++; if (m0_waitrequest !== 1'b0 || mem_write !== 1'b0) begin fails++; $display("FAIL rd_wait wait=%b wr=%b want 0 0", m0_waitrequest, mem_write); end
    checks++; if (m0_readdatavalid !== 1'b0) begin fails++; $display("FAIL wr_novalid got %b want 0", m0_readdatavalid); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (m0_readdatavalid !== 1'b1 || m1_readdatavalid !== 1'b0) begin fails++; $display("FAIL rd_valid got %b%b want 10", m0_readdatavalid, m1_readdatavalid); end
    checks++; if (m0_readdata !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data got %h want deadbeef", m0_readdata); end
  endtask

  task automatic test_byte_lanes();
    @(negedge clk);
    drive_m1(0, 1, 14'h10, 4'hF, 32'h11223344);
    @(negedge clk);
    drive_m1(0, 1, 14'h10, 4'h8, 32'hAA000000);
    #1;
    checks++; if (mem_byteenable !== 4'h8) begin fails++; $display("FAIL be_mux got %h want 8", mem_byteenable); end
    @(negedge clk);
    drive_m1(1, 0, 14'h10, 4'hF, 32'h0);
    @(negedge clk);
    idle();
    #1;
    checks++; if (m1_readdatavalid !== 1'b1 || m0_readdatavalid !== 1'b0) begin fails++; $display("FAIL be_valid got %b%b want 01", m0_readdatavalid, m1_readdatavalid); end
    checks++; if (m1_readdata !== 32'hAA223344) begin fails++; $display("FAIL be_data got %h want aa223344", m1_readdata); end
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    drive_m0(0, 1, 14'd10000, 4'hF, 32'h12345678);
    #1;
    checks++; if (m0_waitrequest !== 1'b0) begin fails++; $display("FAIL oor_wr_wait got %b want 0", m0_waitrequest); end
    checks++; if (mem_chipselect !== 1'b0) begin fails++; $display("FAIL oor_wr_cs got %b want 0", mem_chipselect); end
    @(negedge clk);
    drive_m0(1, 0, 14'd10000, 4'hF, 32'h0);
    #1;
    checks++; if (m0_waitrequest !== 1'b0) begin fails++; $display("FAIL oor_rd_wait got %b want 0", m0_waitrequest); end
    checks++; if (ram[10000] === 32'h12345678) begin fails++; $display("FAIL oor_ram got %h want untouched", ram[10000]); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h0) begin fails++; $display("FAIL oor_rd valid=%b data=%h want 1 00000000", m0_readdatavalid, m0_readdata); end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    drive_m1(1, 0, 14'h10, 4'hF, 32'h0);
    #1;
    checks++; if (m1_waitrequest !== 1'b0) begin fails++; $display("FAIL mr_accept got %b want 0", m1_waitrequest); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive_m0(1, 0, 14'h11, 4'hF, 32'h0);
    #1;
    checks++; if (m1_readdatavalid !== 1'b0) begin fails++; $display("FAIL mr_valid got %b want 0", m1_readdatavalid); end
    checks++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin fails++; $display("FAIL mr_wait got %b%b want 11", m0_waitrequest, m1_waitrequest); end
    @(negedge clk);
    #1;
    checks++; if (m1_readdatavalid !== 1'b0 || mem_chipselect !== 1'b0) begin fails++; $display("FAIL mr_hold valid=%b cs=%b want 0 0", m1_readdatavalid, mem_chipselect); end
    @(negedge clk);
    idle();
    reset = 1'b0;
    wait_ready();
    checks++; if (m1_readdatavalid !== 1'b0) begin fails++; $display("FAIL mr_after got %b want 0", m1_readdatavalid); end
  endtask

`ifdef ONCHIP_MEM_CLEAR_EN
  task automatic test_clear();
    int busy_cycles = 0;
    int wait_bad = 0;
    @(negedge clk);
    drive_m0(0, 1, 14'd9999, 4'hF, 32'hFFFFFFFF);
    @(negedge clk);
    drive_m0(1, 0, 14'd9999, 4'hF, 32'h0);
    @(negedge clk);
    idle();
    #1;
    checks++; if (m0_readdata !== 32'hFFFFFFFF) begin fails++; $display("FAIL clr_preload got %h want ffffffff", m0_readdata); end
    @(negedge clk);
    reset = 1'b1;
    drive_m0(1, 0, 14'd9999, 4'hF, 32'h0);
    drive_m1(1, 0, 14'd0, 4'hF, 32'h0);
    #1;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL clr_rst_busy got %b want 0", busy); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    while (busy === 1'b1 && busy_cycles < 10100) begin
      busy_cycles++;
      if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) wait_bad++;
      @(negedge clk);
      #1;
    end
    checks++; if (busy_cycles != 10000) begin fails++; $display("FAIL clr_len got %0d want 10000", busy_cycles); end
    checks++; if (wait_bad != 0) begin fails++; $display("FAIL clr_wait got %0d low cycles want 0", wait_bad); end
    checks++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin fails++; $display("FAIL clr_first_grant got %b%b want 01", m0_waitrequest, m1_waitrequest); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h0) begin fails++; $display("FAIL clr_read valid=%b data=%h want 1 0", m0_readdatavalid, m0_readdata); end
  endtask
`endif

  initial begin
    idle();
    test_reset();
    apply_reset();
    test_round_robin();
    test_write_read();
    test_byte_lanes();
    test_out_of_range();
    test_reset_mid_read();
`ifdef ONCHIP_MEM_CLEAR_EN
    test_clear();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
